// File: rtl/present_ti_pkg.sv
// Shared types for the serial threshold PRESENT S-layer: FSM states, share nibble,
// widened g-stage word and the plain S-box table used only as a reference value.
package present_ti_pkg;

  typedef logic [3:0] share_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // g-stage word per share: {x2x3, x1x3, x1x2, x0x3, x0x1, x3..x0}
  localparam int GW = 9;
  typedef logic [GW-1:0] gexp_t;

  // Nibble k holds S(k)
  localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

  function automatic share_t sbox_ref(input share_t x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/present_sbox_ti_core.sv
// Two-stage 3-share PRESENT S-box: registered quadratic expansion g, combinational quadratic f.
// One-cycle latency through the g register; en=0 freezes the g register.
module present_sbox_ti_core
  import present_ti_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  share_t a1,
  input  share_t a2,
  input  share_t a3,
  output share_t y1,
  output share_t y2,
  output share_t y3
);

  // S = f(g(x)): g lifts x to its linear bits plus the pairwise products the
  // cubic terms need, so both f and g are quadratic in their own inputs.
  function automatic gexp_t g_map(input share_t x);
    return {x[2] & x[3], x[1] & x[3], x[1] & x[2], x[0] & x[3], x[0] & x[1], x};
  endfunction

  function automatic share_t f_map(input gexp_t u);
    logic   x0, x1, x2, x3, p01, p03, p12, p13, p23;
    share_t y;
    {p23, p13, p12, p03, p01, x3, x2, x1, x0} = u;
    y[0] = x0 ^ x2 ^ x3 ^ p12;
    y[1] = x1 ^ x3 ^ p13 ^ p23 ^ (x0 & p12) ^ (x0 & p13) ^ (x0 & p23);
    y[2] = 1'b1 ^ p01 ^ x2 ^ x3 ^ p03 ^ p13 ^ (x0 & p13) ^ (x0 & p23);
    y[3] = 1'b1 ^ x0 ^ x1 ^ x3 ^ p12 ^ (x0 & p12) ^ (x0 & p13) ^ (x0 & p23);
    return y;
  endfunction

  gexp_t g1_d, g2_d, g3_d;
  gexp_t g1_q, g2_q, g3_q;

  // Non-complete sharing of a quadratic Q: share i = Q(b^c) ^ Q(c), never touching share i
  assign g1_d = g_map(a2 ^ a3) ^ g_map(a3);
  assign g2_d = g_map(a3 ^ a1) ^ g_map(a1);
  assign g3_d = g_map(a1 ^ a2) ^ g_map(a2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g1_q <= '0;
      g2_q <= '0;
      g3_q <= '0;
    end else if (en) begin
      g1_q <= g1_d;
      g2_q <= g2_d;
      g3_q <= g3_d;
    end
  end

  // The constant term of f lands on share 3 only
  assign y1 = f_map(g2_q ^ g3_q) ^ f_map(g3_q);
  assign y2 = f_map(g3_q ^ g1_q) ^ f_map(g1_q);
  assign y3 = f_map(g1_q ^ g2_q) ^ f_map(g2_q) ^ f_map('0);

endmodule

// File: rtl/present_sbox_ti_seq.sv
// Serial 3-share PRESENT S-layer, one nibble per cycle; NIBBLES+1 cycles accept-to-out_valid.
// Result held in DONE until out_ready, input taken only in IDLE; PRESENT_SBOX_TI_SEQ_REFRESH_EN adds rnd remasking.
module present_sbox_ti_seq
  import present_ti_pkg::*;
#(
  parameter int NIBBLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_s1,
  input  logic [4*NIBBLES-1:0] in_s2,
  input  logic [4*NIBBLES-1:0] in_s3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_s1,
  output logic [4*NIBBLES-1:0] out_s2,
  output logic [4*NIBBLES-1:0] out_s3,
`ifdef PRESENT_SBOX_TI_SEQ_REFRESH_EN
  input  logic [7:0]           rnd,
`endif
  output logic                 busy
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  typedef logic [NIBBLES-1:0][3:0] nib_vec_t;

  state_t   state_q, state_d;
  logic [CW-1:0] cnt_q;
  nib_vec_t work1_q, work2_q, work3_q;
  nib_vec_t out1_q, out2_q, out3_q;
  share_t   nib1, nib2, nib3;
  share_t   core_a1, core_a2, core_a3;
  share_t   core_y1, core_y2, core_y3;
  logic     core_en;
  logic     accept;
  logic     cnt_last;

  assign accept   = in_valid & in_ready;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (cnt_last)  state_d = DRAIN;
      DRAIN:                  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign core_en   = (state_q == RUN);

  // Counter clears on the accepting edge and parks at the last nibble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      work1_q <= '0;
      work2_q <= '0;
      work3_q <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      work1_q <= in_s1;
      work2_q <= in_s2;
      work3_q <= in_s3;
    end else if (state_q == RUN && !cnt_last) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign nib1 = work1_q[cnt_q];
  assign nib2 = work2_q[cnt_q];
  assign nib3 = work3_q[cnt_q];

`ifdef PRESENT_SBOX_TI_SEQ_REFRESH_EN
  // Fresh mask pair per nibble; r0 and r1 each appear twice, so the shared value is untouched
  assign core_a1 = nib1 ^ rnd[3:0];
  assign core_a2 = nib2 ^ rnd[7:4];
  assign core_a3 = nib3 ^ rnd[3:0] ^ rnd[7:4];
`else
  assign core_a1 = nib1;
  assign core_a2 = nib2;
  assign core_a3 = nib3;
`endif

  present_sbox_ti_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (core_en),
    .a1    (core_a1),
    .a2    (core_a2),
    .a3    (core_a3),
    .y1    (core_y1),
    .y2    (core_y2),
    .y3    (core_y3)
  );

  // Core output trails its input by one cycle: nibble cnt-1 in RUN, the last nibble in DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_q <= '0;
      out2_q <= '0;
      out3_q <= '0;
    end else if (state_q == RUN && cnt_q != '0) begin
      out1_q[cnt_q - CW'(1)] <= core_y1;
      out2_q[cnt_q - CW'(1)] <= core_y2;
      out3_q[cnt_q - CW'(1)] <= core_y3;
    end else if (state_q == DRAIN) begin
      out1_q[NIBBLES-1] <= core_y1;
      out2_q[NIBBLES-1] <= core_y2;
      out3_q[NIBBLES-1] <= core_y3;
    end
  end

  assign out_s1 = out1_q;
  assign out_s2 = out2_q;
  assign out_s3 = out3_q;

endmodule

// File: tb/tb_present_sbox_ti_seq.sv
// Randomised bench for present_sbox_ti_seq against a nibble-table model of the PRESENT S-layer.
module tb_present_sbox_ti_seq;
  import present_ti_pkg::*;

  localparam logic [63:0] KAT_IN  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_OUT = 64'hC56B90AD3EF84712;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [63:0] in_s1 = '0, in_s2 = '0, in_s3 = '0;
  logic [63:0] out_s1, out_s2, out_s3;
`ifdef PRESENT_SBOX_TI_SEQ_REFRESH_EN
  logic [7:0]  rnd = '0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] x, s2, s3, o1, o2, o3, y, xb, b1, b2, b3;
  int          leaks, lat, bad_rdy;

  always #5 clk = ~clk;

  present_sbox_ti_seq #(.NIBBLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s1     (in_s1),
    .in_s2     (in_s2),
    .in_s3     (in_s3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s1    (out_s1),
    .out_s2    (out_s2),
    .out_s3    (out_s3),
`ifdef PRESENT_SBOX_TI_SEQ_REFRESH_EN
    .rnd       (rnd),
`endif
    .busy      (busy)
  );

`ifdef PRESENT_SBOX_TI_SEQ_REFRESH_EN
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd = 8'($urandom);
    end
  end
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] slayer(input logic [63:0] v);
    logic [63:0] r;
    for (int k = 0; k < 16; k++) r[4*k +: 4] = sbox_ref(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic do_op(input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] a3,
                       input int hold, output logic [63:0] r1, output logic [63:0] r2,
                       output logic [63:0] r3);
    int l;
    wait_ready();
    in_s1 = a1; in_s2 = a2; in_s3 = a3;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    in_s1 = rand64(); in_s2 = rand64(); in_s3 = rand64();
    l = 0;
    while (!out_valid && l < 40) begin
      tick();
      l++;
    end
    chk("latency", 64'(l), 64'd17);
    r1 = out_s1; r2 = out_s2; r3 = out_s3;
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_vld", 64'(out_valid), 64'd1);
        chk("hold_in_rdy", 64'(in_ready), 64'd0);
        chk("hold_s1", out_s1, r1);
        chk("hold_s2", out_s2, r2);
        chk("hold_s3", out_s3, r3);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("release_in_rdy", 64'(in_ready), 64'd1);
      chk("release_vld", 64'(out_valid), 64'd0);
    end else begin
      tick();
      chk("idle_after_done", 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_s1", out_s1, 64'd0);
    chk("rst_out_s2", out_s2, 64'd0);
    chk("rst_out_s3", out_s3, 64'd0);
    rst_n = 1'b1;
    tick();

    // Known answer with the trivial sharing
    do_op(KAT_IN, 64'd0, 64'd0, 0, o1, o2, o3);
    chk("kat_const", o1 ^ o2 ^ o3, KAT_OUT);
    chk("kat_model", o1 ^ o2 ^ o3, slayer(KAT_IN));

    // Same state under random sharings
    for (int i = 0; i < 5; i++) begin
      s2 = rand64();
      s3 = rand64();
      do_op(KAT_IN ^ s2 ^ s3, s2, s3, 0, o1, o2, o3);
      chk("kat_shared", o1 ^ o2 ^ o3, KAT_OUT);
    end

    // Random states and sharings; track any output share equal to the unshared result
    leaks = 0;
    for (int i = 0; i < 1000; i++) begin
      x  = rand64();
      s2 = rand64();
      s3 = rand64();
      do_op(x ^ s2 ^ s3, s2, s3, 0, o1, o2, o3);
      y = slayer(x);
      chk("rand_xor", o1 ^ o2 ^ o3, y);
      if (o1 == y || o2 == y || o3 == y) leaks++;
    end
    chk("share_leak", 64'(leaks), 64'd0);

    // Backpressure in DONE
    x = rand64(); s2 = rand64(); s3 = rand64();
    do_op(x ^ s2 ^ s3, s2, s3, 10, o1, o2, o3);
    chk("bp_xor", o1 ^ o2 ^ o3, slayer(x));

    // Reset while RUN at cnt=7
    wait_ready();
    x = rand64(); s2 = rand64(); s3 = rand64();
    in_s1 = x ^ s2 ^ s3; in_s2 = s2; in_s3 = s3;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_out_s1", out_s1, 64'd0);
    chk("mid_rst_out_s2", out_s2, 64'd0);
    chk("mid_rst_out_s3", out_s3, 64'd0);
    tick();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    x = rand64(); s2 = rand64(); s3 = rand64();
    do_op(x ^ s2 ^ s3, s2, s3, 0, o1, o2, o3);
    chk("post_rst_xor", o1 ^ o2 ^ o3, slayer(x));

    // Back-to-back with in_valid held high; B must not be taken while busy
    wait_ready();
    x  = rand64(); s2 = rand64(); s3 = rand64();
    xb = rand64(); b2 = rand64(); b3 = rand64();
    b1 = xb ^ b2 ^ b3;
    in_s1 = x ^ s2 ^ s3; in_s2 = s2; in_s3 = s3;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("b2b_busy1", 64'(busy), 64'd1);
    in_s1 = b1; in_s2 = b2; in_s3 = b3;
    lat = 0; bad_rdy = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) bad_rdy++;
      tick();
      lat++;
    end
    chk("b2b_lat1", 64'(lat), 64'd17);
    chk("b2b_rdy_while_busy", 64'(bad_rdy), 64'd0);
    chk("b2b_done_in_rdy", 64'(in_ready), 64'd0);
    chk("b2b_res1", out_s1 ^ out_s2 ^ out_s3, slayer(x));
    tick();
    chk("b2b_idle_rdy", 64'(in_ready), 64'd1);
    chk("b2b_idle_busy", 64'(busy), 64'd0);
    tick();
    chk("b2b_accept2", 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk("b2b_lat2", 64'(lat), 64'd17);
    chk("b2b_res2", out_s1 ^ out_s2 ^ out_s3, slayer(xb));
    tick();
    chk("b2b_end_rdy", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
